// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/mem/writeback
// and drives every datapath select/enable plus the 3-bit ALU op.
// Ports: clk, rst_n (sync, active low), op/funct from IR, zero from ALU;
// outputs pc_en, iord, mem_write, ir_write, memtoreg, regdst, reg_write,
// alu_srca, alu_srcb, pc_src, alu_control, illegal_op, state (debug).
module mips_multicycle_ctrl #(
  parameter bit ENABLE_ADDI = 1'b1,
  parameter bit ENABLE_JUMP = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       memtoreg,
  output logic       regdst,
  output logic       reg_write,
  output logic       alu_srca,
  output logic [1:0] alu_srcb,
  output logic [1:0] pc_src,
  output logic [2:0] alu_control,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t cur, nxt;
  logic   pc_write;
  logic   branch;
  logic   funct_ok;
  logic [2:0] r_alu;

  always_ff @(posedge clk) begin
    if (!rst_n) cur <= FETCH;
    else        cur <= nxt;
  end

  always_comb begin
    funct_ok = 1'b1;
    r_alu    = ALU_ADD;
    case (funct)
      6'b100000: r_alu = ALU_ADD;
      6'b100010: r_alu = ALU_SUB;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b101010: r_alu = ALU_SLT;
      default:   funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    nxt         = FETCH;
    pc_write    = 1'b0;
    branch      = 1'b0;
    iord        = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    reg_write   = 1'b0;
    alu_srca    = 1'b0;
    alu_srcb    = 2'b00;
    pc_src      = 2'b00;
    alu_control = ALU_ADD;
    illegal_op  = 1'b0;
    unique case (cur)
      FETCH: begin
        ir_write = 1'b1;
        alu_srcb = 2'b01;
        pc_write = 1'b1;
        nxt      = DECODE;
      end
      DECODE: begin
        alu_srcb = 2'b11;
        case (op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_R: begin
            if (funct_ok) nxt = EXECUTE;
            else          illegal_op = 1'b1;
          end
          OP_BEQ: nxt = BRANCH;
          OP_ADDI: begin
            if (ENABLE_ADDI) nxt = ADDIEX;
            else             illegal_op = 1'b1;
          end
          OP_J: begin
            if (ENABLE_JUMP) nxt = JUMP;
            else             illegal_op = 1'b1;
          end
          default: illegal_op = 1'b1;
        endcase
      end
      MEMADR: begin
        alu_srca = 1'b1;
        alu_srcb = 2'b10;
        if (op == OP_LW)      nxt = MEMRD;
        else if (op == OP_SW) nxt = MEMWR;
      end
      MEMRD: begin
        iord = 1'b1;
        nxt  = MEMWB;
      end
      MEMWB: begin
        memtoreg  = 1'b1;
        reg_write = 1'b1;
      end
      MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      EXECUTE: begin
        alu_srca    = 1'b1;
        alu_control = r_alu;
        nxt         = ALUWB;
      end
      ALUWB: begin
        regdst    = 1'b1;
        reg_write = 1'b1;
      end
      BRANCH: begin
        alu_srca    = 1'b1;
        alu_control = ALU_SUB;
        branch      = 1'b1;
        pc_src      = 2'b01;
      end
      ADDIEX: begin
        alu_srca = 1'b1;
        alu_srcb = 2'b10;
        nxt      = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
      end
      JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: begin
        // Unreachable codes 12-15: recover to FETCH, everything quiet.
        alu_control = 3'b000;
      end
    endcase
    pc_en = pc_write | (branch & zero);
    state = cur;
    // Reset masks every output so no partial write escapes mid-instruction.
    if (!rst_n) begin
      pc_en       = 1'b0;
      iord        = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      memtoreg    = 1'b0;
      regdst      = 1'b0;
      reg_write   = 1'b0;
      alu_srca    = 1'b0;
      alu_srcb    = 2'b00;
      pc_src      = 2'b00;
      alu_control = 3'b000;
      illegal_op  = 1'b0;
      state       = 4'd0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed self-checking bench for mips_multicycle_ctrl.
// Compares the packed output vector against hand-written per-state values.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pc_en, iord, mem_write, ir_write;
  logic       memtoreg, regdst, reg_write, alu_srca;
  logic [1:0] alu_srcb, pc_src;
  logic [2:0] alu_control;
  logic       illegal_op;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .pc_en(pc_en), .iord(iord), .mem_write(mem_write),
    .ir_write(ir_write), .memtoreg(memtoreg), .regdst(regdst),
    .reg_write(reg_write), .alu_srca(alu_srca), .alu_srcb(alu_srcb),
    .pc_src(pc_src), .alu_control(alu_control),
    .illegal_op(illegal_op), .state(state)
  );

  // {state,pc_en,iord,mem_write,ir_write,memtoreg,regdst,reg_write,
  //  alu_srca,alu_srcb,pc_src,alu_control,illegal_op}
  logic [19:0] obs;
  assign obs = {state, pc_en, iord, mem_write, ir_write, memtoreg,
                regdst, reg_write, alu_srca, alu_srcb, pc_src,
                alu_control, illegal_op};

  function automatic logic [19:0] v(
    input logic [3:0] s, input logic pe, input logic io,
    input logic mw, input logic irw, input logic m2r,
    input logic rd, input logic rw, input logic sa,
    input logic [1:0] sb, input logic [1:0] ps,
    input logic [2:0] ac, input logic il);
    return {s, pe, io, mw, irw, m2r, rd, rw, sa, sb, ps, ac, il};
  endfunction

  logic [19:0] e_f, e_d, e_dill, e_ma, e_mr, e_mwb, e_mwr;
  logic [19:0] e_aw, e_ae, e_aiw, e_j;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [19:0] z;
    z = '0;
    rst_n = 1'b0;
    op = 6'b0;
    funct = 6'b0;
    zero = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (obs !== z) begin
        failures++;
        $display("FAIL reset_hold%0d got=%h want=%h", i, obs, z);
      end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== e_f) begin
      failures++;
      $display("FAIL reset_release got=%h want=%h", obs, e_f);
    end
  endtask

  task automatic test_lw();
    logic [19:0] seq [5];
    seq = '{e_f, e_d, e_ma, e_mr, e_mwb};
    op = 6'b100011;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs !== seq[i]) begin
        failures++;
        $display("FAIL lw_step%0d got=%h want=%h", i, obs, seq[i]);
      end
      step();
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fn [5];
    logic [2:0] ac [5];
    logic [19:0] seq [4];
    fn = '{6'b100010, 6'b101010, 6'b100000, 6'b100100, 6'b100101};
    ac = '{3'b110, 3'b111, 3'b010, 3'b000, 3'b001};
    op = 6'b000000;
    for (int k = 0; k < 5; k++) begin
      funct = fn[k];
      seq = '{e_f, e_d,
              v(4'd6,0,0,0,0,0,0,0,1,2'b00,2'b00,ac[k],0), e_aw};
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs !== seq[i]) begin
          failures++;
          $display("FAIL rtype_f%b_step%0d got=%h want=%h",
                   fn[k], i, obs, seq[i]);
        end
        step();
      end
    end
  endtask

  task automatic test_beq();
    logic [19:0] seq [3];
    op = 6'b000100;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      seq = '{e_f, e_d,
              v(4'd8,z[0],0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0)};
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs !== seq[i]) begin
          failures++;
          $display("FAIL beq_z%0d_step%0d got=%h want=%h",
                   z, i, obs, seq[i]);
        end
        step();
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_addi_jump();
    logic [19:0] sa [4];
    logic [19:0] sj [3];
    sa = '{e_f, e_d, e_ae, e_aiw};
    sj = '{e_f, e_d, e_j};
    op = 6'b001000;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== sa[i]) begin
        failures++;
        $display("FAIL addi_step%0d got=%h want=%h", i, obs, sa[i]);
      end
      step();
    end
    op = 6'b000010;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs !== sj[i]) begin
        failures++;
        $display("FAIL jump_step%0d got=%h want=%h", i, obs, sj[i]);
      end
      step();
    end
  endtask

  task automatic test_illegal();
    logic [5:0] ops [2];
    logic [5:0] fns [2];
    logic [19:0] seq [3];
    ops = '{6'b111111, 6'b000000};
    fns = '{6'b100000, 6'b000000};
    seq = '{e_f, e_dill, e_f};
    for (int k = 0; k < 2; k++) begin
      op = ops[k];
      funct = fns[k];
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs !== seq[i]) begin
          failures++;
          $display("FAIL illegal%0d_step%0d got=%h want=%h",
                   k, i, obs, seq[i]);
        end
        if (i < 2) step();
      end
    end
  endtask

  task automatic test_back_to_back_reset_sw();
    logic [19:0] seq [4];
    seq = '{e_f, e_d, e_ma, e_mwr};
    op = 6'b101011;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== seq[i]) begin
        failures++;
        $display("FAIL sw_step%0d got=%h want=%h", i, obs, seq[i]);
      end
      if (i < 3) step();
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 20'h0) begin
      failures++;
      $display("FAIL sw_reset_mask got=%h want=%h", obs, 20'h0);
    end
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== e_f) begin
      failures++;
      $display("FAIL sw_reset_refetch got=%h want=%h", obs, e_f);
    end
    op = 6'b100011;
    step();
    checks++;
    if (obs !== e_d) begin
      failures++;
      $display("FAIL sw_reset_resume got=%h want=%h", obs, e_d);
    end
  endtask

  initial begin
    e_f    = v(4'd0,1,0,0,1,0,0,0,0,2'b01,2'b00,3'b010,0);
    e_d    = v(4'd1,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0);
    e_dill = v(4'd1,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,1);
    e_ma   = v(4'd2,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0);
    e_mr   = v(4'd3,0,1,0,0,0,0,0,0,2'b00,2'b00,3'b010,0);
    e_mwb  = v(4'd4,0,0,0,0,1,0,1,0,2'b00,2'b00,3'b010,0);
    e_mwr  = v(4'd5,0,1,1,0,0,0,0,0,2'b00,2'b00,3'b010,0);
    e_aw   = v(4'd7,0,0,0,0,0,1,1,0,2'b00,2'b00,3'b010,0);
    e_ae   = v(4'd9,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0);
    e_aiw  = v(4'd10,0,0,0,0,0,0,1,0,2'b00,2'b00,3'b010,0);
    e_j    = v(4'd11,1,0,0,0,0,0,0,0,2'b00,2'b10,3'b010,0);
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_addi_jump();
    test_illegal();
    test_back_to_back_reset_sw();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Control FSM for the multicycle MIPS datapath; sits directly upstream of the ALU.
- Decodes op/funct from the instruction register and sequences fetch, decode, execute, memory and writeback steps.
- Drives every datapath select and enable, including the 3-bit alu_control consumed by the ALU.
- Uses the ALU zero flag to resolve beq.

Parameters:
- ENABLE_ADDI, 1: 1 = addi supported; 0 = opcode 001000 treated as illegal.
- ENABLE_JUMP, 1: 1 = j supported; 0 = opcode 000010 treated as illegal.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous reset, active low.
- op  input  6  instr[31:26] from instruction register.
- funct  input  6  instr[5:0] from instruction register.
- zero  input  1  ALU zero flag, valid during BRANCH.
- pc_en  output  1  PC register enable.
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  output  1  memory write strobe.
- ir_write  output  1  instruction register load.
- memtoreg  output  1  register write data: 0 = ALUOut, 1 = Data.
- regdst  output  1  destination register: 0 = rt, 1 = rd.
- reg_write  output  1  register file write strobe.
- alu_srca  output  1  ALU A: 0 = PC, 1 = A register.
- alu_srcb  output  2  ALU B: 00 = B reg, 01 = const 4, 10 = signext imm, 11 = signext imm<<2.
- pc_src  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_control  output  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- illegal_op  output  1  one-cycle pulse in DECODE when op/funct is unsupported.
- state  output  4  current state encoding, for debug and bench.

Behaviour:
- Clocking: single clock. Registered 4-bit state. All outputs are combinational Moore decodes of state.
  - Exception: pc_en = pc_write | (branch & zero).
  - Exception: illegal_op and the R-type alu_control also decode op/funct.
- Reset: rst_n sampled at posedge; low forces state = FETCH (0). While rst_n is low, all outputs are forced to 0, including pc_en and ir_write. Reset mid-instruction abandons it; no partial writes after the reset edge.
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12-15 are unreachable and go to FETCH with all outputs 0.
- FETCH: iord=0, ir_write=1, alu_srca=0, alu_srcb=01, alu_control=010, pc_src=00, pc_write=1. Next DECODE.
- DECODE: alu_srca=0, alu_srcb=11, alu_control=010 (branch target precompute). Next state by op:
  - 100011 or 101011 -> MEMADR
  - 000000 with supported funct -> EXECUTE
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - anything else -> FETCH with illegal_op=1
- MEMADR: alu_srca=1, alu_srcb=10, alu_control=010. Next MEMRD if op=100011, MEMWR if op=101011.
- MEMRD: iord=1. Next MEMWB.
- MEMWB: regdst=0, memtoreg=1, reg_write=1. Next FETCH.
- MEMWR: iord=1, mem_write=1. Next FETCH.
- EXECUTE: alu_srca=1, alu_srcb=00. alu_control from funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111. Next ALUWB.
- ALUWB: regdst=1, memtoreg=0, reg_write=1. Next FETCH.
- BRANCH: alu_srca=1, alu_srcb=00, alu_control=110, branch=1, pc_src=01. pc_en=zero. Next FETCH.
- ADDIEX: alu_srca=1, alu_srcb=10, alu_control=010. Next ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, reg_write=1. Next FETCH.
- JUMP: pc_src=10, pc_write=1. Next FETCH.
- Defaults: outputs not listed for a state are 0, except alu_control, which defaults to 010. alu_control is never X.
- Latency in cycles including FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- op/funct must be stable from DECODE through end of instruction (IR is held while ir_write=0).

Test Plan:
- Reset: rst_n=0 for 2 cycles, then 1 -> all outputs 0 during reset; first cycle after release state=0, ir_write=1, pc_en=1, alu_srcb=01.
- lw (op=100011) -> state sequence 0,1,2,3,4,0; reg_write=1 with memtoreg=1 only in state 4; iord=1 in state 3.
- R-type sub (op=000000, funct=100010) -> state 6 drives alu_control=110, alu_srcb=00; state 7 reg_write=1, regdst=1; slt funct=101010 gives 111.
- beq (op=000100): zero=1 in BRANCH -> pc_en=1, pc_src=01; repeat with zero=0 -> pc_en=0; both return to FETCH.
- Illegal op=111111 in DECODE -> illegal_op=1 for one cycle, next state 0, no reg_write/mem_write. Same for R-type funct=000000.
- Reset asserted during MEMWR (sw) -> mem_write=0 in the reset cycle; state=0 after the edge; normal fetch resumes.
